uart_tx_arbiter: RTL and testbench

Shares the single TX FIFO write port (Write_Req_Sig / FIFO_Write_Data / Full_Sig) between two byte-stream requesters. Requester 0 is the RX-to-TX echo path from the inter-control logic; requester 1 is a local message/status generator. Packets are atomic: once granted, a requester keeps the port until its Last byte, so bytes of different messages never interleave on the UART line. A stall watchdog prevents a requester from holding the port indefinitely.

---
 rtl/uart_tx_arbiter_pkg.sv | 12 +
 rtl/uart_arb_watchdog.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared state encodings and byte width for the TX FIFO arbiter
package uart_tx_arbiter_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_arb_watchdog.sv
// rtl/uart_arb_watchdog.sv - stall counter that flags expiry after TIMEOUT_CYCLES idle cycles
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   inc       - count one idle cycle
//   clr       - clear the count (has priority over inc)
//   expire    - count has reached TIMEOUT_CYCLES
module uart_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic expire
);

    logic [CNT_W-1:0] count;

    assign expire = (count == CNT_W'(TIMEOUT_CYCLES));

    // Holding at the expiry value keeps the counter from wrapping if the
    // owner does not clear it in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-atomic round-robin arbiter for the shared TX FIFO write port
//
// Optional feature macro: UART_TX_ARB_STATS_EN (adds Pkt_Cnt0/Pkt_Cnt1 packet counters).
//
// Ports:
//   CLK, RST              - clock, synchronous active-high reset
//   Req0/Data0/Last0/Ack0 - requester 0 (echo path) byte stream, Ack0 same-cycle accept
//   Req1/Data1/Last1/Ack1 - requester 1 (message generator) byte stream
//   Full_Sig              - TX FIFO full
//   Write_Req_Sig         - TX FIFO write strobe (one-cycle pulse)
//   FIFO_Write_Data       - TX FIFO write data
//   Grant                 - one-hot owner, 00 when idle
//   Timeout_Pulse         - one-cycle pulse when the watchdog forces a release
//   Pkt_Cnt0/Pkt_Cnt1     - saturating completed-packet counters (stats build only)
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req0,
    input  logic [DATA_W-1:0] Data0,
    input  logic              Last0,
    output logic              Ack0,
    input  logic              Req1,
    input  logic [DATA_W-1:0] Data1,
    input  logic              Last1,
    output logic              Ack1,
    input  logic              Full_Sig,
    output logic              Write_Req_Sig,
    output logic [DATA_W-1:0] FIFO_Write_Data,
    output logic [1:0]        Grant,
    output logic              Timeout_Pulse
`ifdef UART_TX_ARB_STATS_EN
    ,
    output logic [15:0]       Pkt_Cnt0,
    output logic [15:0]       Pkt_Cnt1
`endif
);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic              rr_ptr;
    logic              rr_ptr_nx;
    logic              owning;
    logic              own_req;
    logic              own_last;
    logic [DATA_W-1:0] own_data;
    logic              accept;
    logic              timeout;
    logic              expire;
    logic              wd_inc;
    logic              wd_clr;

    assign Grant = {state == OWN1, state == OWN0};

    // Next-state, accept and watchdog control
    always_comb begin
        owning    = 1'b0;
        own_req   = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        state_nx  = state;
        rr_ptr_nx = rr_ptr;

        case (state)
            OWN0: begin
                owning   = 1'b1;
                own_req  = Req0;
                own_last = Last0;
                own_data = Data0;
            end
            OWN1: begin
                owning   = 1'b1;
                own_req  = Req1;
                own_last = Last1;
                own_data = Data1;
            end
            default: ;
        endcase

        timeout = owning && expire;
        // Write_Req_Sig low spaces writes two cycles apart so Full_Sig has
        // caught up with the previous write; a timeout beats a late Req.
        accept  = owning && own_req && !Full_Sig && !Write_Req_Sig && !timeout;
        Ack0    = accept && (state == OWN0);
        Ack1    = accept && (state == OWN1);

        case (state)
            IDLE: begin
                // rr_ptr names the last requester served; the other wins a tie.
                if (Req0 && Req1) begin
                    state_nx = rr_ptr ? OWN0 : OWN1;
                end else if (Req0) begin
                    state_nx = OWN0;
                end else if (Req1) begin
                    state_nx = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (timeout || (accept && own_last)) begin
                    state_nx  = IDLE;
                    rr_ptr_nx = (state == OWN1);
                end
            end
            default: state_nx = IDLE;
        endcase

        // Backpressure with Req held high never counts as idle.
        wd_inc = owning && !own_req;
        wd_clr = accept || (state_nx != state);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            rr_ptr <= 1'b1;
        end else begin
            state  <= state_nx;
            rr_ptr <= rr_ptr_nx;
        end
    end

    // FIFO write register and timeout pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            Write_Req_Sig   <= 1'b0;
            FIFO_Write_Data <= '0;
            Timeout_Pulse   <= 1'b0;
        end else begin
            Write_Req_Sig <= accept;
            Timeout_Pulse <= timeout;
            if (accept) begin
                FIFO_Write_Data <= own_data;
            end
        end
    end

    uart_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk   (CLK),
        .rst   (RST),
        .inc   (wd_inc),
        .clr   (wd_clr),
        .expire(expire)
    );

`ifdef UART_TX_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            Pkt_Cnt0 <= '0;
            Pkt_Cnt1 <= '0;
        end else begin
            if (Ack0 && Last0 && (Pkt_Cnt0 != 16'hFFFF)) begin
                Pkt_Cnt0 <= Pkt_Cnt0 + 16'd1;
            end
            if (Ack1 && Last1 && (Pkt_Cnt1 != 16'hFFFF)) begin
                Pkt_Cnt1 <= Pkt_Cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int TMO = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Req0 = 1'b0, Last0 = 1'b0, Req1 = 1'b0, Last1 = 1'b0;
    logic [7:0] Data0 = 8'h00, Data1 = 8'h00;
    logic       Full_Sig = 1'b0;
    logic       Ack0, Ack1, Write_Req_Sig, Timeout_Pulse;
    logic [7:0] FIFO_Write_Data;
    logic [1:0] Grant;
`ifdef UART_TX_ARB_STATS_EN
    logic [15:0] Pkt_Cnt0, Pkt_Cnt1;
`endif

    always #5 CLK = ~CLK;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .Req0(Req0), .Data0(Data0), .Last0(Last0), .Ack0(Ack0),
        .Req1(Req1), .Data1(Data1), .Last1(Last1), .Ack1(Ack1),
        .Full_Sig(Full_Sig), .Write_Req_Sig(Write_Req_Sig),
        .FIFO_Write_Data(FIFO_Write_Data), .Grant(Grant),
        .Timeout_Pulse(Timeout_Pulse)
`ifdef UART_TX_ARB_STATS_EN
        , .Pkt_Cnt0(Pkt_Cnt0), .Pkt_Cnt1(Pkt_Cnt1)
`endif
    );

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester queues: bit 8 = last flag, bits 7:0 = byte
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit         rand_gaps = 0;
    int         gap0 = 0, gap1 = 0;

    task automatic push_pkt(input int who, input int len);
        logic [8:0] e;
        for (int i = 0; i < len; i++) begin
            e = {(i == len - 1), 8'($urandom)};
            if (who == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    // Requester driver: advances on Ack, drives inputs 2 time units after the edge
    logic da0, da1;
    initial begin
        forever begin
            @(negedge CLK);
            da0 = Ack0;
            da1 = Ack1;
            @(posedge CLK);
            #2;
            if (da0 && q0.size() > 0) void'(q0.pop_front());
            if (da1 && q1.size() > 0) void'(q1.pop_front());
            if (rand_gaps) begin
                if (gap0 > 0) gap0--; else if ($urandom_range(0, 19) == 0) gap0 = $urandom_range(1, 12);
                if (gap1 > 0) gap1--; else if ($urandom_range(0, 19) == 0) gap1 = $urandom_range(1, 12);
            end else begin
                gap0 = 0;
                gap1 = 0;
            end
            Req0  = (q0.size() > 0) && (gap0 == 0);
            Data0 = (q0.size() > 0) ? q0[0][7:0] : 8'($urandom);
            Last0 = (q0.size() > 0) ? q0[0][8] : 1'($urandom);
            Req1  = (q1.size() > 0) && (gap1 == 0);
            Data1 = (q1.size() > 0) ? q1[0][7:0] : 8'($urandom);
            Last1 = (q1.size() > 0) ? q1[0][8] : 1'($urandom);
        end
    end

    // Behavioural model: owner id, last served requester, idle run length,
    // whether a write went out last cycle. Checked every negedge.
    int         m_owner = -1;
    int         m_served = 1;
    int         m_idle = 0;
    bit         m_wr = 0;
    bit         m_to = 0;
    logic [7:0] m_wd = 8'h00;
    int         m_cnt0 = 0, m_cnt1 = 0;
    logic [7:0] wlog[$];
    int         plog[$];

    bit         mtmo, macc, mreq, mlast;
    logic [7:0] mdata;

    initial begin
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            mreq  = (m_owner == 0) ? Req0 : (m_owner == 1) ? Req1 : 1'b0;
            mlast = (m_owner == 0) ? Last0 : Last1;
            mdata = (m_owner == 0) ? Data0 : Data1;
            mtmo  = (m_owner >= 0) && (m_idle == TMO);
            macc  = (m_owner >= 0) && !mtmo && mreq && !Full_Sig && !m_wr;

            chk("ack0", Ack0, macc && m_owner == 0);
            chk("ack1", Ack1, macc && m_owner == 1);
            chk("grant", Grant, (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00);
            chk("wr", Write_Req_Sig, m_wr);
            chk("wdata", FIFO_Write_Data, m_wd);
            chk("timeout", Timeout_Pulse, m_to);
`ifdef UART_TX_ARB_STATS_EN
            chk("pkt_cnt0", Pkt_Cnt0, m_cnt0);
            chk("pkt_cnt1", Pkt_Cnt1, m_cnt1);
`endif
            if (Write_Req_Sig) wlog.push_back(FIFO_Write_Data);
            if (macc && mlast) plog.push_back(m_owner);

            if (RST) begin
                m_owner = -1; m_served = 1; m_idle = 0;
                m_wr = 0; m_to = 0; m_wd = 8'h00; m_cnt0 = 0; m_cnt1 = 0;
            end else if (m_owner < 0) begin
                if (Req0 && Req1) m_owner = 1 - m_served;
                else if (Req0) m_owner = 0;
                else if (Req1) m_owner = 1;
                m_idle = 0; m_wr = 0; m_to = 0;
            end else begin
                m_wr = macc;
                m_to = mtmo;
                if (mtmo) begin
                    m_served = m_owner; m_owner = -1; m_idle = 0;
                end else if (macc) begin
                    m_wd = mdata;
                    m_idle = 0;
                    if (mlast) begin
                        if (m_owner == 0 && m_cnt0 < 65535) m_cnt0++;
                        if (m_owner == 1 && m_cnt1 < 65535) m_cnt1++;
                        m_served = m_owner; m_owner = -1;
                    end
                end else if (!mreq) begin
                    m_idle++;
                end
            end
        end
    end

    task automatic pulse_reset();
        @(posedge CLK); #1;
        RST = 1'b1; q0.delete(); q1.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic wait_ack(input int who, input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!((who == 0) ? Ack0 : Ack1) && n < 40);
        if (n >= 40) begin
            compared++; mismatched++;
            $display("FAIL %s: no ack within 40 cycles", name);
        end
    endtask

    logic [7:0] ackv, wrv;
    logic [7:0] wd_tr[1:8];
    logic [1:0] gr_tr[1:8];
    logic [7:0] t2_exp[4];
    int         n, cnt_a, cnt_w, cnt_t;

    initial begin
        t2_exp = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_grant", Grant, 2'b00);
        chk("rst_wr", Write_Req_Sig, 1'b0);
        chk("rst_wdata", FIFO_Write_Data, 8'h00);
        chk("rst_timeout", Timeout_Pulse, 1'b0);

        // 1: single 3-byte packet from requester 0
        @(posedge CLK); #1;
        RST = 1'b0;
        q0 = '{9'h041, 9'h042, 9'h143};
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            ackv[k-1] = Ack0;
            wrv[k-1]  = Write_Req_Sig;
            wd_tr[k]  = FIFO_Write_Data;
            gr_tr[k]  = Grant;
        end
        chk("t1_ack_cycles", ackv, 8'h2A);
        chk("t1_wr_cycles", wrv, 8'h54);
        chk("t1_data_c3", wd_tr[3], 8'h41);
        chk("t1_data_c5", wd_tr[5], 8'h42);
        chk("t1_data_c7", wd_tr[7], 8'h43);
        chk("t1_grant_c6", gr_tr[6], 2'b01);
        chk("t1_grant_c7", gr_tr[7], 2'b00);

        // 2: both requesters from reset, requester 0 wins, no interleave
        pulse_reset();
        wlog.delete();
        q0 = '{9'h0A0, 9'h1A1};
        q1 = '{9'h0B0, 9'h1B1};
        repeat (20) @(negedge CLK);
        chk("t2_count", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) chk("t2_order", wlog[i], t2_exp[i]);

        // 3: continuous streaming alternates owners
        @(posedge CLK); #1;
        plog.delete();
        for (int p = 0; p < 4; p++) begin
            push_pkt(0, $urandom_range(1, 3));
            push_pkt(1, $urandom_range(1, 3));
        end
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(negedge CLK);
        chk("t3_count", plog.size(), 8);
        for (int i = 0; i < plog.size(); i++) chk("t3_alternate", plog[i], i % 2);

        // 4: FIFO full for 50 cycles while owning, no ack/write/timeout
        @(posedge CLK); #1;
        Full_Sig = 1'b1;
        q0 = '{9'h0C0, 9'h1C1};
        cnt_a = 0; cnt_w = 0; cnt_t = 0;
        repeat (50) begin
            @(negedge CLK);
            cnt_a += Ack0; cnt_w += Write_Req_Sig; cnt_t += Timeout_Pulse;
        end
        chk("t4_grant", Grant, 2'b01);
        chk("t4_acks", cnt_a, 0);
        chk("t4_writes", cnt_w, 0);
        chk("t4_timeouts", cnt_t, 0);
        @(posedge CLK); #1;
        Full_Sig = 1'b0;
        wlog.delete();
        repeat (15) @(negedge CLK);
        chk("t4_write_count", wlog.size(), 2);
        if (wlog.size() > 0) chk("t4_first_byte", wlog[0], 8'hC0);

        // 5: stalled packet times out, pending requester 1 then granted
        @(posedge CLK); #1;
        q0 = '{9'h055};
        wait_ack(0, "t5_ack0");
        @(posedge CLK); #1;
        q1 = '{9'h166};
        // Accept clears the watchdog; TMO idle cycles are then counted,
        // expiry is seen on the next cycle and the pulse is registered.
        n = 1;
        @(negedge CLK);
        while (!Timeout_Pulse && n < 30) begin
            @(negedge CLK);
            n++;
        end
        chk("t5_latency", n, TMO + 2);
        chk("t5_grant_at_pulse", Grant, 2'b00);
        @(negedge CLK);
        chk("t5_grant_next", Grant, 2'b10);
        repeat (6) @(negedge CLK);

        // 6: reset while requester 1 is mid-packet
        @(posedge CLK); #1;
        q1 = '{9'h071, 9'h072, 9'h173};
        wait_ack(1, "t6_ack1");
        repeat (2) @(negedge CLK);
        @(posedge CLK); #1;
        RST = 1'b1; q0.delete(); q1.delete();
        @(posedge CLK);
        @(negedge CLK);
        chk("t6_grant", Grant, 2'b00);
        chk("t6_wr", Write_Req_Sig, 1'b0);
        chk("t6_wdata", FIFO_Write_Data, 8'h00);
        chk("t6_timeout", Timeout_Pulse, 1'b0);
`ifdef UART_TX_ARB_STATS_EN
        chk("t6_cnt0", Pkt_Cnt0, 16'd0);
        chk("t6_cnt1", Pkt_Cnt1, 16'd0);
`endif
        @(posedge CLK); #1;
        RST = 1'b0;

        // Random traffic: random backpressure, request gaps long enough to time out
        rand_gaps = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #1;
            Full_Sig = ($urandom_range(0, 9) < 3);
            if (q0.size() < 4 && $urandom_range(0, 3) == 0) push_pkt(0, $urandom_range(1, 5));
            if (q1.size() < 4 && $urandom_range(0, 3) == 0) push_pkt(1, $urandom_range(1, 5));
        end
        @(posedge CLK); #1;
        rand_gaps = 0;
        Full_Sig = 1'b0;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || Grant != 2'b00) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 500) begin
            compared++; mismatched++;
            $display("FAIL drain: traffic not drained within 500 cycles");
        end
        repeat (3) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
